// File: rtl/dyuv_line_sequencer.sv
// ============================================================================
// dyuv_line_sequencer: per-scanline controller for the delta-YUV decoder.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dyuv_line_sequencer #(
  parameter int          CNT_W     = 10,
  parameter logic [23:0] RESET_YUV = 24'h108080
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line_start,
  input  logic             dyuv_enable,
  input  logic [CNT_W-1:0] line_width,
  input  logic             start_yuv_we,
  input  logic [23:0]      start_yuv_in,
  output logic [23:0]      dec_start_yuv,
  output logic             dec_reset,
  input  logic             dec_write,
  output logic             dec_strobe,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [CNT_W-1:0] pix_x,
  output logic             line_done,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_pix_x;
  logic [23:0]      r_shadow;
  logic [23:0]      r_active;
  logic             r_overrun;

  logic w_accept;
  logic w_last;
  logic w_take;

  assign w_accept = line_start & dyuv_enable;
  assign w_last   = (r_pix_x == (r_width - c_one));
  // A line_start in RUN pre-empts the pixel, so the decoder is not acknowledged.
  assign w_take   = (r_state == RUN) & ~line_start & ~reset;

  assign pix_valid     = w_take & dec_write;
  assign dec_strobe    = w_take & dec_write & pix_ready;
  assign dec_reset     = reset | (r_state == ARM) | (r_state == FLUSH);
  assign line_done     = ~reset & (r_state == FLUSH);
  assign busy          = ~reset & (r_state != IDLE);
  assign pix_x         = r_pix_x;
  assign overrun       = r_overrun;
  assign dec_start_yuv = r_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_width   <= '0;
      r_pix_x   <= '0;
      r_shadow  <= RESET_YUV;
      r_active  <= RESET_YUV;
      r_overrun <= 1'b0;
    end else begin
      if (start_yuv_we)
        r_shadow <= start_yuv_in;
      // Write-through lets a same-cycle register write reach this line.
      if (w_accept)
        r_active <= start_yuv_we ? start_yuv_in : r_shadow;

      if (r_state == IDLE) begin
        if (w_accept) begin
          r_width <= line_width;
          r_pix_x <= '0;
          r_state <= ARM;
        end
      end else if (line_start) begin
        r_overrun <= 1'b1;
        if (dyuv_enable) begin
          r_width <= line_width;
          r_pix_x <= '0;
          r_state <= ARM;
        end else begin
          r_state <= FLUSH;
        end
      end else begin
        case (r_state)
          ARM:   r_state <= (r_width == '0) ? FLUSH : RUN;
          RUN: begin
            if (dec_strobe) begin
              if (w_last)
                r_state <= FLUSH;
              else
                r_pix_x <= r_pix_x + c_one;
            end
          end
          FLUSH: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dyuv_line_sequencer.sv
// ============================================================================
// tb_dyuv_line_sequencer: directed self-checking bench for dyuv_line_sequencer.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dyuv_line_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic        dyuv_enable;
  logic [9:0]  line_width;
  logic        start_yuv_we;
  logic [23:0] start_yuv_in;
  logic [23:0] dec_start_yuv;
  logic        dec_reset;
  logic        dec_write;
  logic        dec_strobe;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic        line_done;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dyuv_line_sequencer #(.CNT_W(10), .RESET_YUV(24'h108080)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .dyuv_enable(dyuv_enable),
    .line_width(line_width), .start_yuv_we(start_yuv_we), .start_yuv_in(start_yuv_in),
    .dec_start_yuv(dec_start_yuv), .dec_reset(dec_reset), .dec_write(dec_write),
    .dec_strobe(dec_strobe), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .line_done(line_done), .busy(busy), .overrun(overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick; #2;
    total++; if (dec_reset !== 1'b1) begin bad++; $display("FAIL rst_dec_reset got=%b exp=1", dec_reset); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (pix_x !== 10'd0) begin bad++; $display("FAIL rst_pix_x got=%0d exp=0", pix_x); end
    total++; if (dec_start_yuv !== 24'h108080) begin bad++; $display("FAIL rst_yuv got=%h exp=108080", dec_start_yuv); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    total++; if (line_done !== 1'b0 || pix_valid !== 1'b0 || dec_strobe !== 1'b0) begin bad++; $display("FAIL rst_outs got=%b%b%b exp=000", line_done, pix_valid, dec_strobe); end
    tick; reset = 1'b0; #2;
    total++; if (dec_reset !== 1'b0) begin bad++; $display("FAIL rst_release got=%b exp=0", dec_reset); end
  endtask

  task automatic test_basic;
    tick; start_yuv_we = 1'b1; start_yuv_in = 24'h408090;
    tick; start_yuv_we = 1'b0; #2;
    total++; if (dec_start_yuv !== 24'h108080) begin bad++; $display("FAIL basic_shadow_only got=%h exp=108080", dec_start_yuv); end
    tick; line_start = 1'b1; dyuv_enable = 1'b1; line_width = 10'd4; dec_write = 1'b1; pix_ready = 1'b1; #2;
    total++; if (dec_strobe !== 1'b0) begin bad++; $display("FAIL basic_idle_strobe got=%b exp=0", dec_strobe); end
    tick; line_start = 1'b0; #2;
    total++; if (dec_reset !== 1'b1) begin bad++; $display("FAIL basic_arm_reset got=%b exp=1", dec_reset); end
    total++; if (dec_start_yuv !== 24'h408090) begin bad++; $display("FAIL basic_yuv got=%h exp=408090", dec_start_yuv); end
    total++; if (dec_strobe !== 1'b0 || pix_valid !== 1'b0) begin bad++; $display("FAIL basic_arm_hs got=%b%b exp=00", dec_strobe, pix_valid); end
    for (int i = 0; i < 4; i++) begin
      tick; #2;
      total++; if (pix_x !== 10'(i)) begin bad++; $display("FAIL basic_pix_x got=%0d exp=%0d", pix_x, i); end
      total++; if (dec_strobe !== 1'b1 || dec_reset !== 1'b0) begin bad++; $display("FAIL basic_run got=%b%b exp=10", dec_strobe, dec_reset); end
    end
    tick; dec_write = 1'b0; #2;
    total++; if (line_done !== 1'b1 || dec_reset !== 1'b1 || pix_valid !== 1'b0) begin bad++; $display("FAIL basic_flush got=%b%b%b exp=110", line_done, dec_reset, pix_valid); end
    tick; #2;
    total++; if (busy !== 1'b0 || line_done !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b%b exp=00", busy, line_done); end
    total++; if (pix_x !== 10'd3) begin bad++; $display("FAIL basic_hold_x got=%0d exp=3", pix_x); end
  endtask

  task automatic test_backpressure;
    int exp_x = 0;
    int n_strobe = 0;
    tick; line_start = 1'b1; line_width = 10'd6; dec_write = 1'b1; pix_ready = 1'b0;
    tick; line_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick; pix_ready = ((c % 4) == 0) || ((c % 4) == 3); #2;
      total++; if (dec_strobe !== pix_ready) begin bad++; $display("FAIL bp_strobe c=%0d got=%b exp=%b", c, dec_strobe, pix_ready); end
      total++; if (pix_x !== 10'(exp_x)) begin bad++; $display("FAIL bp_pix_x c=%0d got=%0d exp=%0d", c, pix_x, exp_x); end
      if (dec_strobe === 1'b1) n_strobe++;
      if (pix_ready && exp_x < 5) exp_x++;
    end
    tick; dec_write = 1'b0; #2;
    total++; if (n_strobe !== 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", n_strobe); end
    total++; if (line_done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", line_done); end
    tick; #2;
    total++; if (line_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b%b exp=00", line_done, busy); end
  endtask

  task automatic test_shadow;
    pix_ready = 1'b1;
    tick; line_start = 1'b1; line_width = 10'd2; dec_write = 1'b1;
    tick; line_start = 1'b0;
    tick; start_yuv_we = 1'b1; start_yuv_in = 24'h10A0B0; #2;
    total++; if (dec_start_yuv !== 24'h408090) begin bad++; $display("FAIL shd_we_cycle got=%h exp=408090", dec_start_yuv); end
    tick; start_yuv_we = 1'b0; #2;
    total++; if (dec_start_yuv !== 24'h408090) begin bad++; $display("FAIL shd_after_we got=%h exp=408090", dec_start_yuv); end
    tick; tick; #2;
    total++; if (dec_start_yuv !== 24'h408090) begin bad++; $display("FAIL shd_idle got=%h exp=408090", dec_start_yuv); end
    tick; line_start = 1'b1; line_width = 10'd1;
    tick; line_start = 1'b0; #2;
    total++; if (dec_start_yuv !== 24'h10A0B0) begin bad++; $display("FAIL shd_next_line got=%h exp=10a0b0", dec_start_yuv); end
    tick; tick; tick;
    tick; line_start = 1'b1; start_yuv_we = 1'b1; start_yuv_in = 24'h223344;
    tick; line_start = 1'b0; start_yuv_we = 1'b0; #2;
    total++; if (dec_start_yuv !== 24'h223344) begin bad++; $display("FAIL shd_writethru got=%h exp=223344", dec_start_yuv); end
    tick; tick; tick; #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL shd_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_overrun;
    tick; line_start = 1'b1; line_width = 10'd8; dec_write = 1'b1; pix_ready = 1'b1;
    tick; line_start = 1'b0;
    tick; tick; tick;
    tick; line_start = 1'b1; line_width = 10'd2; #2;
    total++; if (dec_strobe !== 1'b0 || line_done !== 1'b0) begin bad++; $display("FAIL ovr_collide got=%b%b exp=00", dec_strobe, line_done); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre got=%b exp=0", overrun); end
    tick; line_start = 1'b0; #2;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    total++; if (pix_x !== 10'd0 || dec_reset !== 1'b1 || line_done !== 1'b0) begin bad++; $display("FAIL ovr_arm x=%0d rst=%b done=%b exp x=0 rst=1 done=0", pix_x, dec_reset, line_done); end
    tick; #2;
    total++; if (pix_x !== 10'd0 || dec_strobe !== 1'b1) begin bad++; $display("FAIL ovr_run0 x=%0d stb=%b exp x=0 stb=1", pix_x, dec_strobe); end
    tick; #2;
    total++; if (pix_x !== 10'd1) begin bad++; $display("FAIL ovr_run1 got=%0d exp=1", pix_x); end
    tick; dec_write = 1'b0; #2;
    total++; if (line_done !== 1'b1) begin bad++; $display("FAIL ovr_done got=%b exp=1", line_done); end
    tick; #2;
    total++; if (overrun !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ovr_sticky ovr=%b busy=%b exp ovr=1 busy=0", overrun, busy); end
  endtask

  task automatic test_edge;
    tick; line_start = 1'b1; line_width = 10'd0; dec_write = 1'b1; pix_ready = 1'b1;
    tick; line_start = 1'b0; #2;
    total++; if (dec_reset !== 1'b1 || line_done !== 1'b0) begin bad++; $display("FAIL w0_arm rst=%b done=%b exp rst=1 done=0", dec_reset, line_done); end
    tick; #2;
    total++; if (line_done !== 1'b1 || dec_strobe !== 1'b0) begin bad++; $display("FAIL w0_flush done=%b stb=%b exp done=1 stb=0", line_done, dec_strobe); end
    tick; dec_write = 1'b0; #2;
    total++; if (busy !== 1'b0 || pix_x !== 10'd0) begin bad++; $display("FAIL w0_idle busy=%b x=%0d exp busy=0 x=0", busy, pix_x); end
    tick; line_start = 1'b1; dyuv_enable = 1'b0; line_width = 10'd5;
    tick; line_start = 1'b0; dyuv_enable = 1'b1; #2;
    total++; if (dec_reset !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dis_ignored rst=%b busy=%b exp rst=0 busy=0", dec_reset, busy); end
  endtask

  task automatic test_reset_mid;
    tick; line_start = 1'b1; line_width = 10'd5; dec_write = 1'b1; pix_ready = 1'b1;
    tick; line_start = 1'b0;
    tick; tick; tick; #2;
    total++; if (pix_x !== 10'd2) begin bad++; $display("FAIL rm_pre got=%0d exp=2", pix_x); end
    reset = 1'b1; #1;
    total++; if (dec_reset !== 1'b1 || dec_strobe !== 1'b0) begin bad++; $display("FAIL rm_during rst=%b stb=%b exp rst=1 stb=0", dec_reset, dec_strobe); end
    tick; reset = 1'b0; dec_write = 1'b0; #2;
    total++; if (busy !== 1'b0 || pix_x !== 10'd0) begin bad++; $display("FAIL rm_state busy=%b x=%0d exp busy=0 x=0", busy, pix_x); end
    total++; if (dec_start_yuv !== 24'h108080 || overrun !== 1'b0) begin bad++; $display("FAIL rm_regs yuv=%h ovr=%b exp yuv=108080 ovr=0", dec_start_yuv, overrun); end
  endtask

  initial begin
    reset = 1'b1; line_start = 1'b0; dyuv_enable = 1'b1; line_width = '0;
    start_yuv_we = 1'b0; start_yuv_in = '0; dec_write = 1'b0; pix_ready = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_shadow;
    test_overrun;
    test_edge;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
